// File: rtl/branch_ctrl.sv
// ============================================================================
// Module      : branch_ctrl
// Description : Branch resolution and pipeline-redirect controller with
//               predict-not-taken, timed IF/ID and ID/EX flush, and
//               saturating branch/taken statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_ctrl #(
    parameter int PC_W         = 16,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic [4:0]       ex_op,
    input  logic             ex_zero,
    input  logic             ex_ltz,
    input  logic [PC_W-1:0]  ex_target,
    input  logic             stall,
    input  logic             clr_cnt,
    output logic             redirect,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             busy,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam logic [0:0] c_idle  = 1'b0;
    localparam logic [0:0] c_flush = 1'b1;

    localparam int                  c_fcnt_w    = 3;
    localparam logic [c_fcnt_w-1:0] c_fcnt_init = c_fcnt_w'(FLUSH_CYCLES - 1);

    localparam logic [4:0] c_op_beqz = 5'b01100;
    localparam logic [4:0] c_op_bnez = 5'b01101;
    localparam logic [4:0] c_op_bgez = 5'b01110;
    localparam logic [4:0] c_op_bltz = 5'b01111;

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [c_fcnt_w-1:0] r_fcnt;
    logic [c_fcnt_w-1:0] w_fcnt_nxt;

    logic                w_is_branch;
    logic                w_taken;
    logic                w_accept;

    logic                r_redirect;
    logic                w_redirect_nxt;
    logic [PC_W-1:0]     r_redirect_pc;
    logic [PC_W-1:0]     w_redirect_pc_nxt;
    logic                r_flush;
    logic                w_flush_nxt;
    logic [CNT_W-1:0]    r_br_cnt;
    logic [CNT_W-1:0]    r_taken_cnt;

    // Branch decision from the ALU flags
    always_comb begin
        w_is_branch = 1'b0;
        w_taken     = 1'b0;
        case (ex_op)
            c_op_beqz: begin
                w_is_branch = 1'b1;
                w_taken     = ex_zero;
            end
            c_op_bnez: begin
                w_is_branch = 1'b1;
                w_taken     = !ex_zero;
            end
            c_op_bgez: begin
                w_is_branch = 1'b1;
                w_taken     = !ex_ltz || ex_zero;
            end
            c_op_bltz: begin
                w_is_branch = 1'b1;
                w_taken     = ex_ltz && !ex_zero;
            end
            default: begin
                w_is_branch = 1'b0;
                w_taken     = 1'b0;
            end
        endcase
    end

    assign w_accept = ex_valid && w_is_branch && !stall && (r_state == c_idle);

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_idle;
            r_fcnt        <= '0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_flush       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_fcnt        <= w_fcnt_nxt;
            r_redirect    <= w_redirect_nxt;
            r_redirect_pc <= w_redirect_pc_nxt;
            r_flush       <= w_flush_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        if (!stall) begin
            case (r_state)
                c_idle: begin
                    if (w_accept && w_taken) begin
                        w_state_nxt = c_flush;
                        w_fcnt_nxt  = c_fcnt_init;
                    end
                end
                c_flush: begin
                    if (r_fcnt == '0) begin
                        w_state_nxt = c_idle;
                    end else begin
                        w_fcnt_nxt = r_fcnt - 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = c_idle;
                    w_fcnt_nxt  = '0;
                end
            endcase
        end
    end

    // Redirect pulses only on entry to FLUSH; flushes span the whole FLUSH
    always_comb begin
        w_redirect_nxt    = r_redirect;
        w_redirect_pc_nxt = r_redirect_pc;
        w_flush_nxt       = r_flush;
        if (!stall) begin
            case (r_state)
                c_idle: begin
                    w_redirect_nxt = 1'b0;
                    w_flush_nxt    = 1'b0;
                    if (w_accept && w_taken) begin
                        w_redirect_nxt    = 1'b1;
                        w_redirect_pc_nxt = ex_target;
                        w_flush_nxt       = 1'b1;
                    end
                end
                c_flush: begin
                    w_redirect_nxt = 1'b0;
                    if (r_fcnt == '0) begin
                        w_flush_nxt = 1'b0;
                    end
                end
                default: begin
                    w_redirect_nxt = 1'b0;
                    w_flush_nxt    = 1'b0;
                end
            endcase
        end
    end

    // Statistics counters: clear wins over a same-cycle increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_br_cnt    <= '0;
            r_taken_cnt <= '0;
        end else if (clr_cnt) begin
            r_br_cnt    <= '0;
            r_taken_cnt <= '0;
        end else if (w_accept) begin
            if (r_br_cnt != '1) begin
                r_br_cnt <= r_br_cnt + 1'b1;
            end
            if (w_taken && (r_taken_cnt != '1)) begin
                r_taken_cnt <= r_taken_cnt + 1'b1;
            end
        end
    end

    assign redirect    = r_redirect;
    assign redirect_pc = r_redirect_pc;
    assign flush_ifid  = r_flush;
    assign flush_idex  = r_flush;
    assign busy        = (r_state == c_flush);
    assign br_cnt      = r_br_cnt;
    assign taken_cnt   = r_taken_cnt;

endmodule

`default_nettype wire

// File: tb/tb_branch_ctrl.sv
// ============================================================================
// Module      : tb_branch_ctrl
// Description : Self-checking bench for branch_ctrl against a behavioural
//               reference model (flush countdown, signed-value branch rules).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_ctrl;

    localparam int PC_W = 16;
    localparam int FC   = 2;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            ex_valid;
    logic [4:0]      ex_op;
    logic            ex_zero;
    logic            ex_ltz;
    logic [PC_W-1:0] ex_target;
    logic            stall;
    logic            clr_cnt;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic            flush_ifid;
    logic            flush_idex;
    logic            busy;
    logic [CW-1:0]   br_cnt;
    logic [CW-1:0]   taken_cnt;

    branch_ctrl #(.PC_W(PC_W), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_op(ex_op),
        .ex_zero(ex_zero), .ex_ltz(ex_ltz), .ex_target(ex_target),
        .stall(stall), .clr_cnt(clr_cnt), .redirect(redirect),
        .redirect_pc(redirect_pc), .flush_ifid(flush_ifid),
        .flush_idex(flush_idex), .busy(busy), .br_cnt(br_cnt),
        .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int              m_left;
    bit              m_redirect;
    logic [PC_W-1:0] m_pc;
    int              m_br;
    int              m_tk;

    function automatic bit is_br(input logic [4:0] op);
        return (op >= 5'd12) && (op <= 5'd15);
    endfunction

    // Flags describe a register value: zero, negative or positive
    function automatic bit ref_taken(input logic [4:0] op, input logic z, input logic l);
        int v;
        v = z ? 0 : (l ? -1 : 1);
        case (op)
            5'd12:   return v == 0;
            5'd13:   return v != 0;
            5'd14:   return v >= 0;
            5'd15:   return v < 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] exp_ctl();
        return {m_redirect, m_left > 0, m_left > 0, m_left > 0};
    endfunction

    task automatic model_clear();
        m_left = 0; m_redirect = 0; m_pc = '0; m_br = 0; m_tk = 0;
    endtask

    task automatic idle_inputs();
        ex_valid = 0; ex_op = 5'd0; ex_zero = 0; ex_ltz = 0;
        ex_target = '0; stall = 0; clr_cnt = 0;
    endtask

    task automatic drive_br(input logic [4:0] op, input logic z, input logic l,
                            input logic [PC_W-1:0] tgt);
        ex_valid = 1; ex_op = op; ex_zero = z; ex_ltz = l; ex_target = tgt;
    endtask

    // Advance the model with the inputs present at the coming edge, then clock
    task automatic step();
        bit t;
        if (!rst) begin
            if (clr_cnt) begin
                m_br = 0; m_tk = 0;
            end
            if (!stall) begin
                if (m_left > 0) begin
                    m_redirect = 0;
                    m_left--;
                end else if (ex_valid && is_br(ex_op)) begin
                    t = ref_taken(ex_op, ex_zero, ex_ltz);
                    if (!clr_cnt) begin
                        if (m_br < CMAX) m_br++;
                        if (t && m_tk < CMAX) m_tk++;
                    end
                    if (t) begin
                        m_left = FC; m_redirect = 1; m_pc = ex_target;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        model_clear();
        #7;
        checks++;
        if ({redirect, flush_ifid, flush_idex, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctl: got %b expected 0000", {redirect, flush_ifid, flush_idex, busy});
        end
        checks++;
        if ({br_cnt, taken_cnt, redirect_pc} !== '0) begin
            errors++;
            $display("FAIL reset_data: got br=%0d tk=%0d pc=%h expected zeros", br_cnt, taken_cnt, redirect_pc);
        end
        rst = 0;
        step();
        checks++;
        if ({redirect, busy, br_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_release: got redirect=%b busy=%b br=%0d expected 0", redirect, busy, br_cnt);
        end
    endtask

    task automatic test_beqz_basic();
        drive_br(5'b01100, 1'b1, 1'b0, 16'h0040);
        step();
        idle_inputs();
        checks++;
        if ({redirect, flush_ifid, flush_idex, busy} !== 4'b1111 || redirect_pc !== 16'h0040) begin
            errors++;
            $display("FAIL beqz_n1: got ctl=%b pc=%h expected 1111 0040", {redirect, flush_ifid, flush_idex, busy}, redirect_pc);
        end
        step();
        checks++;
        if ({redirect, flush_ifid, flush_idex, busy} !== 4'b0111) begin
            errors++;
            $display("FAIL beqz_n2: got ctl=%b expected 0111", {redirect, flush_ifid, flush_idex, busy});
        end
        step();
        checks++;
        if ({redirect, flush_ifid, flush_idex, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL beqz_n3: got ctl=%b expected 0000", {redirect, flush_ifid, flush_idex, busy});
        end
        checks++;
        if (br_cnt !== 4'd1 || taken_cnt !== 4'd1) begin
            errors++;
            $display("FAIL beqz_cnt: got br=%0d tk=%0d expected 1 1", br_cnt, taken_cnt);
        end
    endtask

    task automatic test_decision_sweep();
        logic [4:0] ops [5];
        logic [PC_W-1:0] tgt;
        bit exp_t;
        ops = '{5'd0, 5'b01100, 5'b01101, 5'b01110, 5'b01111};
        clr_cnt = 1;
        step();
        clr_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            for (int f = 0; f < 3; f++) begin
                logic z, l;
                if (i == 5 && f > 0) break;
                z = (i == 5) ? 1'b1 : (f == 2);
                l = (i == 5) ? 1'b1 : (f == 1);
                tgt = PC_W'($urandom);
                drive_br((i == 5) ? 5'b01111 : ops[i], z, l, tgt);
                exp_t = ref_taken(ex_op, z, l);
                step();
                idle_inputs();
                checks++;
                if (redirect !== exp_t || (exp_t && redirect_pc !== tgt)) begin
                    errors++;
                    $display("FAIL sweep_op%0d_f%0d: got redirect=%b pc=%h expected %b %h", i, f, redirect, redirect_pc, exp_t, tgt);
                end
                checks++;
                if (br_cnt !== CW'(m_br) || taken_cnt !== CW'(m_tk)) begin
                    errors++;
                    $display("FAIL sweep_cnt_op%0d_f%0d: got br=%0d tk=%0d expected %0d %0d", i, f, br_cnt, taken_cnt, m_br, m_tk);
                end
                for (int k = 0; k < FC; k++) step();
            end
        end
        checks++;
        if (br_cnt !== 4'd13 || taken_cnt !== 4'd6) begin
            errors++;
            $display("FAIL sweep_total: got br=%0d tk=%0d expected 13 6", br_cnt, taken_cnt);
        end
    endtask

    task automatic test_stall();
        int b0;
        b0 = m_br;
        drive_br(5'b01101, 1'b0, 1'b0, 16'h1234);
        step();
        stall = 1;
        drive_br(5'b01100, 1'b1, 1'b0, 16'h0999);
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({redirect, flush_ifid, flush_idex, busy} !== 4'b1111 || redirect_pc !== 16'h1234
                || br_cnt !== CW'(b0 + 1)) begin
                errors++;
                $display("FAIL stall_hold%0d: got ctl=%b pc=%h br=%0d expected 1111 1234 %0d", k, {redirect, flush_ifid, flush_idex, busy}, redirect_pc, br_cnt, b0 + 1);
            end
        end
        idle_inputs();
        step();
        checks++;
        if ({redirect, flush_ifid, flush_idex, busy} !== 4'b0111) begin
            errors++;
            $display("FAIL stall_release: got ctl=%b expected 0111", {redirect, flush_ifid, flush_idex, busy});
        end
        step();
        checks++;
        if ({redirect, flush_ifid, flush_idex, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL stall_end: got ctl=%b expected 0000", {redirect, flush_ifid, flush_idex, busy});
        end
        stall = 1;
        drive_br(5'b01100, 1'b1, 1'b0, 16'h0055);
        step();
        step();
        checks++;
        if (redirect !== 1'b0 || busy !== 1'b0 || br_cnt !== CW'(b0 + 1)) begin
            errors++;
            $display("FAIL stall_idle_branch: got redirect=%b busy=%b br=%0d expected 0 0 %0d", redirect, busy, br_cnt, b0 + 1);
        end
        stall = 0;
        step();
        idle_inputs();
        checks++;
        if (redirect !== 1'b1 || redirect_pc !== 16'h0055 || br_cnt !== CW'(b0 + 2)) begin
            errors++;
            $display("FAIL stall_resolve: got redirect=%b pc=%h br=%0d expected 1 0055 %0d", redirect, redirect_pc, br_cnt, b0 + 2);
        end
        for (int k = 0; k < FC; k++) step();
    endtask

    task automatic test_wrong_path();
        int b0;
        clr_cnt = 1;
        step();
        clr_cnt = 0;
        b0 = m_br;
        drive_br(5'b01100, 1'b1, 1'b0, 16'h0100);
        step();
        drive_br(5'b01100, 1'b1, 1'b0, 16'h0200);
        step();
        checks++;
        if (redirect !== 1'b0 || busy !== 1'b1 || br_cnt !== CW'(b0 + 1)) begin
            errors++;
            $display("FAIL wrongpath_ignored: got redirect=%b busy=%b br=%0d expected 0 1 %0d", redirect, busy, br_cnt, b0 + 1);
        end
        step();
        checks++;
        if (busy !== 1'b0 || redirect !== 1'b0 || redirect_pc !== 16'h0100) begin
            errors++;
            $display("FAIL wrongpath_end: got busy=%b redirect=%b pc=%h expected 0 0 0100", busy, redirect, redirect_pc);
        end
        step();
        idle_inputs();
        checks++;
        if (redirect !== 1'b1 || redirect_pc !== 16'h0200 || br_cnt !== CW'(b0 + 2) || taken_cnt !== 4'd2) begin
            errors++;
            $display("FAIL wrongpath_reaccept: got redirect=%b pc=%h br=%0d tk=%0d expected 1 0200 %0d 2", redirect, redirect_pc, br_cnt, taken_cnt, b0 + 2);
        end
        for (int k = 0; k < FC; k++) step();
    endtask

    task automatic test_counters();
        clr_cnt = 1;
        step();
        clr_cnt = 0;
        drive_br(5'b01101, 1'b1, 1'b0, 16'h0000);
        for (int k = 0; k < 17; k++) step();
        checks++;
        if (br_cnt !== 4'd15 || taken_cnt !== 4'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL cnt_saturate: got br=%0d tk=%0d busy=%b expected 15 0 0", br_cnt, taken_cnt, busy);
        end
        clr_cnt = 1;
        step();
        clr_cnt = 0;
        checks++;
        if (br_cnt !== 4'd0 || taken_cnt !== 4'd0) begin
            errors++;
            $display("FAIL cnt_clear_priority: got br=%0d tk=%0d expected 0 0", br_cnt, taken_cnt);
        end
        step();
        stall = 1;
        clr_cnt = 1;
        step();
        checks++;
        if (br_cnt !== 4'd0) begin
            errors++;
            $display("FAIL cnt_clear_stalled: got br=%0d expected 0", br_cnt);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_back_to_back_random();
        for (int n = 0; n < 400; n++) begin
            ex_valid  = ($urandom_range(0, 3) != 0);
            ex_op     = ($urandom_range(0, 9) < 7) ? 5'(12 + $urandom_range(0, 3)) : 5'($urandom);
            ex_zero   = 1'($urandom);
            ex_ltz    = 1'($urandom);
            ex_target = PC_W'($urandom);
            stall     = ($urandom_range(0, 4) == 0);
            clr_cnt   = ($urandom_range(0, 39) == 0);
            step();
            checks++;
            if ({redirect, flush_ifid, flush_idex, busy} !== exp_ctl() || redirect_pc !== m_pc) begin
                errors++;
                $display("FAIL rand_ctl_%0d: got ctl=%b pc=%h expected %b %h", n, {redirect, flush_ifid, flush_idex, busy}, redirect_pc, exp_ctl(), m_pc);
            end
            checks++;
            if (br_cnt !== CW'(m_br) || taken_cnt !== CW'(m_tk)) begin
                errors++;
                $display("FAIL rand_cnt_%0d: got br=%0d tk=%0d expected %0d %0d", n, br_cnt, taken_cnt, m_br, m_tk);
            end
        end
        idle_inputs();
        for (int k = 0; k < FC + 1; k++) step();
    endtask

    task automatic test_reset_mid_flush();
        drive_br(5'b01110, 1'b0, 1'b0, 16'h0abc);
        step();
        idle_inputs();
        #2;
        rst = 1;
        model_clear();
        #1;
        checks++;
        if ({redirect, flush_ifid, flush_idex, busy} !== 4'b0000 || redirect_pc !== '0
            || br_cnt !== '0 || taken_cnt !== '0) begin
            errors++;
            $display("FAIL reset_mid_flush: got ctl=%b pc=%h br=%0d tk=%0d expected all 0", {redirect, flush_ifid, flush_idex, busy}, redirect_pc, br_cnt, taken_cnt);
        end
        rst = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (redirect !== 1'b0 || busy !== 1'b0 || br_cnt !== '0 || taken_cnt !== '0) begin
                errors++;
                $display("FAIL reset_after_%0d: got redirect=%b busy=%b br=%0d tk=%0d expected 0", k, redirect, busy, br_cnt, taken_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_beqz_basic();
        test_decision_sweep();
        test_stall();
        test_wrong_path();
        test_counters();
        test_back_to_back_random();
        test_reset_mid_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
